pen_frame_buffer: RTL and testbench

Bicolor pixel store for the 8x8 light-pen matrix. It sits directly upstream of led_driver. Pen-side logic writes individual pixels, and the scan side reads one whole row per request as red/green column vectors. It also keeps a running lit-pixel count, which the top level routes into the hex display data word. A clear command wipes the frame over ROWS cycles.

---
 rtl/pen_pkg.sv | 22 ++
 rtl/pen_frame_buffer_row_popcount.sv | 18 +
 rtl/pen_frame_buffer.sv | 141 ++++++++++++++
 tb/tb_pen_frame_buffer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pen_pkg.sv
// Shared definitions for the light-pen matrix: default geometry, colour encoding,
// and the frame-buffer clear FSM states.
package pen_pkg;

    // Default matrix geometry, also used by led_driver.
    localparam int unsigned PEN_ROWS = 8;
    localparam int unsigned PEN_COLS = 8;

    // Pixel colour: bit 0 drives the red LED, bit 1 the green LED.
    typedef logic [1:0] color_t;

    localparam color_t COLOR_OFF    = 2'b00;
    localparam color_t COLOR_RED    = 2'b01;
    localparam color_t COLOR_GREEN  = 2'b10;
    localparam color_t COLOR_YELLOW = 2'b11;

    typedef enum logic {
        StIdle,
        StClear
    } clr_state_e;

endpackage

// File: rtl/pen_frame_buffer_row_popcount.sv
// Combinational ones counter for one matrix row.
module row_popcount #(
    parameter int unsigned COLS = 8,
    parameter int unsigned NW   = 7
) (
    input  logic [COLS-1:0] bits_i,
    output logic [NW-1:0]   count_o
);

    // Sum the set bits of the row.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < COLS; i++) begin
            count_o = count_o + NW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/pen_frame_buffer.sv
// Bicolor 8x8 pixel store: single-pixel writes, registered whole-row reads,
// running lit-pixel count and a one-row-per-cycle clear sweep.
module pen_frame_buffer
    import pen_pkg::*;
#(
    parameter int unsigned ROWS = PEN_ROWS,
    parameter int unsigned COLS = PEN_COLS,
    parameter int unsigned RW   = $clog2(ROWS),
    parameter int unsigned CW   = $clog2(COLS),
    parameter int unsigned NW   = $clog2(ROWS * COLS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [CW-1:0]   wr_col,
    input  logic [1:0]      wr_color,
    input  logic            clear_req,
    input  logic [RW-1:0]   rd_row,
    output logic [COLS-1:0] rd_red,
    output logic [COLS-1:0] rd_green,
    output logic            busy,
    output logic            wr_drop,
    output logic [NW-1:0]   lit_count
);

    clr_state_e      state_q, state_d;
    logic [RW-1:0]   ptr_q, ptr_d;
    logic [COLS-1:0] red_q   [ROWS];
    logic [COLS-1:0] red_d   [ROWS];
    logic [COLS-1:0] green_q [ROWS];
    logic [COLS-1:0] green_d [ROWS];
    logic [COLS-1:0] rd_red_q, rd_red_d;
    logic [COLS-1:0] rd_green_q, rd_green_d;
    logic [NW-1:0]   lit_q, lit_d;

    logic            wr_in_range;
    logic            rd_in_range;
    logic            wr_ok;
    color_t          old_px;
    color_t          new_px;
    logic [COLS-1:0] sweep_bits;
    logic [NW-1:0]   sweep_pop;

    // Only matters at non-power-of-two sizes; indices are zero-extended so the
    // bound itself is representable.
    assign wr_in_range = ({1'b0, wr_row} < (RW + 1)'(ROWS)) &&
                         ({1'b0, wr_col} < (CW + 1)'(COLS));
    assign rd_in_range = ({1'b0, rd_row} < (RW + 1)'(ROWS));

    assign wr_ok   = wr_en && (state_q == StIdle) && !clear_req && wr_in_range;
    assign wr_drop = !rst && wr_en && ((state_q != StIdle) || clear_req || !wr_in_range);

    assign old_px  = {green_q[wr_row][wr_col], red_q[wr_row][wr_col]};
    assign new_px  = color_t'(wr_color);

    // A pixel counts as lit if either colour is on.
    assign sweep_bits = red_q[ptr_q] | green_q[ptr_q];

    row_popcount #(
        .COLS (COLS),
        .NW   (NW)
    ) u_sweep_pop (
        .bits_i  (sweep_bits),
        .count_o (sweep_pop)
    );

    // Clear FSM, pixel writes and lit-count bookkeeping.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        red_d   = red_q;
        green_d = green_q;
        lit_d   = lit_q;
        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end else if (wr_ok) begin
                    red_d[wr_row][wr_col]   = new_px[0];
                    green_d[wr_row][wr_col] = new_px[1];
                    if (old_px == COLOR_OFF && new_px != COLOR_OFF) begin
                        lit_d = lit_q + 1'b1;
                    end else if (old_px != COLOR_OFF && new_px == COLOR_OFF) begin
                        lit_d = lit_q - 1'b1;
                    end
                end
            end
            StClear: begin
                red_d[ptr_q]   = '0;
                green_d[ptr_q] = '0;
                lit_d          = lit_q - sweep_pop;
                ptr_d          = ptr_q + 1'b1;
                if (ptr_q == RW'(ROWS - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Row read samples storage before this cycle's write or sweep lands.
    always_comb begin
        rd_red_d   = '0;
        rd_green_d = '0;
        if (rd_in_range) begin
            rd_red_d   = red_q[rd_row];
            rd_green_d = green_q[rd_row];
        end
    end

    // State, storage and read registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            lit_q      <= '0;
            rd_red_q   <= '0;
            rd_green_q <= '0;
            for (int r = 0; r < ROWS; r++) begin
                red_q[r]   <= '0;
                green_q[r] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lit_q      <= lit_d;
            rd_red_q   <= rd_red_d;
            rd_green_q <= rd_green_d;
            red_q      <= red_d;
            green_q    <= green_d;
        end
    end

    assign rd_red    = rd_red_q;
    assign rd_green  = rd_green_q;
    assign busy      = (state_q == StClear);
    assign lit_count = lit_q;

endmodule

// File: tb/tb_pen_frame_buffer.sv
// Bench for pen_frame_buffer: directed stimulus, row reads checked through a
// scoreboard queue, lit_count/busy checked every cycle against a pixel model.
module tb_pen_frame_buffer;
    import pen_pkg::*;

    localparam int unsigned ROWS = 8;
    localparam int unsigned COLS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [1:0] wr_color;
    logic       clear_req;
    logic [2:0] rd_row;
    logic [7:0] rd_red;
    logic [7:0] rd_green;
    logic       busy;
    logic       wr_drop;
    logic [6:0] lit_count;

    int n_chk  = 0;
    int n_fail = 0;

    pen_frame_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_color  (wr_color),
        .clear_req (clear_req),
        .rd_row    (rd_row),
        .rd_red    (rd_red),
        .rd_green  (rd_green),
        .busy      (busy),
        .wr_drop   (wr_drop),
        .lit_count (lit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read scoreboard.
    typedef struct {
        int         row;
        logic [7:0] red;
        logic [7:0] green;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    logic    rd_req = 1'b0;
    logic    rd_pend = 1'b0;

    task automatic issue_rd(input int row, input logic [7:0] er, input logic [7:0] eg);
        rd_exp_t e;
        e.row   = row;
        e.red   = er;
        e.green = eg;
        rd_q.push_back(e);
        rd_row = 3'(row);
        rd_req = 1'b1;
    endtask

    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                chk("rd_underflow", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk($sformatf("rd_red_row%0d", e.row), 32'(rd_red), 32'(e.red));
                chk($sformatf("rd_green_row%0d", e.row), 32'(rd_green), 32'(e.green));
            end
        end
    end

    // Pixel model for the per-cycle lit_count / busy invariant.
    logic [7:0] m_red   [ROWS];
    logic [7:0] m_green [ROWS];
    logic       m_busy;
    int         m_ptr;
    logic       mon_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                m_red[r]   = 8'h00;
                m_green[r] = 8'h00;
            end
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (m_busy) begin
            m_red[m_ptr]   = 8'h00;
            m_green[m_ptr] = 8'h00;
            if (m_ptr == ROWS - 1) m_busy = 1'b0;
            m_ptr = m_ptr + 1;
        end else if (clear_req) begin
            m_busy = 1'b1;
            m_ptr  = 0;
        end else if (wr_en) begin
            m_red[wr_row][wr_col]   = wr_color[0];
            m_green[wr_row][wr_col] = wr_color[1];
        end
    end

    function automatic int model_lit();
        int n = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (m_red[r][c] || m_green[r][c]) n++;
            end
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("lit_invariant", 32'(lit_count), 32'(model_lit()));
            chk("busy_model", 32'(busy), 32'(m_busy));
        end
    end

    // Complete the current cycle and drop single-cycle strobes.
    task automatic finish_cyc();
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        clear_req = 1'b0;
        rd_req    = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        finish_cyc();
    endtask

    task automatic set_wr(input int row, input int col, input color_t color);
        wr_en    = 1'b1;
        wr_row   = 3'(row);
        wr_col   = 3'(col);
        wr_color = color;
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_row    = '0;
        wr_col    = '0;
        wr_color  = COLOR_OFF;
        clear_req = 1'b0;
        rd_row    = '0;
        step();
        step();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state and empty rows.
        @(negedge clk);
        chk("reset_lit", 32'(lit_count), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_wr_drop", 32'(wr_drop), 32'd0);
        chk("reset_rd_red", 32'(rd_red), 32'd0);
        finish_cyc();
        for (int r = 0; r < ROWS; r++) begin
            issue_rd(r, 8'h00, 8'h00);
            step();
        end

        // Basic writes; red->yellow keeps the count.
        set_wr(2, 5, COLOR_RED);
        @(negedge clk);
        chk("wr_drop_normal", 32'(wr_drop), 32'd0);
        finish_cyc();
        set_wr(2, 5, COLOR_YELLOW);
        step();
        set_wr(7, 0, COLOR_GREEN);
        step();
        issue_rd(2, 8'h20, 8'h20);
        step();
        issue_rd(7, 8'h00, 8'h01);
        @(negedge clk);
        chk("lit_after_writes", 32'(lit_count), 32'd2);
        finish_cyc();

        // Read-before-write on the same row.
        set_wr(2, 5, COLOR_OFF);
        issue_rd(2, 8'h20, 8'h20);
        step();
        issue_rd(2, 8'h00, 8'h00);
        @(negedge clk);
        chk("lit_after_off", 32'(lit_count), 32'd1);
        finish_cyc();

        // Fill frame red, then clear with a colliding write.
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                set_wr(r, c, COLOR_RED);
                step();
            end
        end
        set_wr(0, 0, COLOR_GREEN);
        clear_req = 1'b1;
        @(negedge clk);
        chk("lit_full", 32'(lit_count), 32'd64);
        chk("wr_drop_clear_collide", 32'(wr_drop), 32'd1);
        chk("busy_before_sweep", 32'(busy), 32'd0);
        finish_cyc();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) issue_rd(2, 8'h00, 8'h00);
            if (i == 4) issue_rd(6, 8'hff, 8'h00);
            @(negedge clk);
            chk($sformatf("sweep_busy_%0d", i), 32'(busy), 32'd1);
            chk($sformatf("sweep_lit_%0d", i), 32'(lit_count), 32'(64 - 8 * i));
            finish_cyc();
        end
        @(negedge clk);
        chk("sweep_done_busy", 32'(busy), 32'd0);
        chk("sweep_done_lit", 32'(lit_count), 32'd0);
        finish_cyc();
        for (int r = 0; r < ROWS; r++) begin
            issue_rd(r, 8'h00, 8'h00);
            step();
        end

        // Write and clear_req mid-sweep are dropped / ignored.
        set_wr(1, 1, COLOR_RED);
        step();
        set_wr(3, 3, COLOR_GREEN);
        step();
        set_wr(6, 7, COLOR_YELLOW);
        step();
        clear_req = 1'b1;
        @(negedge clk);
        chk("lit_before_clear2", 32'(lit_count), 32'd3);
        finish_cyc();
        for (int i = 0; i < 9; i++) begin
            if (i == 2) begin
                set_wr(0, 0, COLOR_RED);
                clear_req = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("sweep2_busy_%0d", i), 32'(busy), (i < 8) ? 32'd1 : 32'd0);
            if (i == 2) chk("wr_drop_busy", 32'(wr_drop), 32'd1);
            finish_cyc();
        end
        @(negedge clk);
        chk("sweep2_lit", 32'(lit_count), 32'd0);
        finish_cyc();

        // Reset in the 4th sweep cycle aborts the clear.
        set_wr(0, 0, COLOR_RED);
        step();
        set_wr(4, 4, COLOR_GREEN);
        step();
        set_wr(7, 7, COLOR_YELLOW);
        step();
        set_wr(5, 2, COLOR_RED);
        step();
        issue_rd(7, 8'h80, 8'h80);
        clear_req = 1'b1;
        @(negedge clk);
        chk("lit_before_clear3", 32'(lit_count), 32'd4);
        finish_cyc();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rst = 1'b1;
            @(negedge clk);
            chk($sformatf("sweep3_busy_%0d", i), 32'(busy), 32'd1);
            finish_cyc();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_lit", 32'(lit_count), 32'd0);
        chk("abort_rd_red", 32'(rd_red), 32'd0);
        finish_cyc();
        for (int r = 0; r < ROWS; r++) begin
            issue_rd(r, 8'h00, 8'h00);
            step();
        end

        step();
        step();
        chk("scoreboard_drained", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
